decoder_scan_seq: RTL and testbench

- Upstream driver for the 5-to-32 one-hot decoder (decoder5_32).
- Generates the 5-bit select `B` and enable `E` that sweep an index range.
- Holds each index for a programmable dwell, or advances on single-step strobes.
- Reports busy/done status to a controlling FSM; the decoder's L[31:0] is consumed downstream.

---
 rtl/decoder_scan_pkg.sv | 19 +
 rtl/decoder_scan_seq_if.sv | 30 +++
 rtl/scan_dwell_cnt.sv | 25 ++
 rtl/decoder_scan_seq.sv | 153 +++++++++++++++
 tb/tb_decoder_scan_seq.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/decoder_scan_pkg.sv
// Shared constants for the decoder scan sequencer: state encoding and widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package decoder_scan_pkg;

   localparam int IDX_W_DEF = 5;
   localparam int DWELL_W   = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_FIN  = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_RUN  = ST_RUN,
      S_FIN  = ST_FIN
   } state_t;

endpackage

// File: rtl/decoder_scan_seq_if.sv
// Control and decoder-select bundle between a controlling FSM and the scan sequencer.
// Latency: n/a (wires only). Adds `loop` when DECODER_SCAN_LOOP_EN is defined.
// Backpressure: none; strobes are single-cycle requests.
interface decoder_scan_seq_if #(
   parameter int IDX_W = decoder_scan_pkg::IDX_W_DEF
);
   logic             start;
   logic             stop;
   logic [IDX_W-1:0] first;
   logic [IDX_W-1:0] last;
   logic             step_mode;
   logic             step;
   logic [IDX_W-1:0] B;
   logic             E;
   logic             busy;
   logic             done;
`ifdef DECODER_SCAN_LOOP_EN
   logic             loop;

   modport master (output start, stop, first, last, step_mode, step, loop,
                   input  B, E, busy, done);
   modport slave  (input  start, stop, first, last, step_mode, step, loop,
                   output B, E, busy, done);
`else
   modport master (output start, stop, first, last, step_mode, step,
                   input  B, E, busy, done);
   modport slave  (input  start, stop, first, last, step_mode, step,
                   output B, E, busy, done);
`endif
endinterface

// File: rtl/scan_dwell_cnt.sv
// Dwell counter: counts enabled cycles, tc flags count==DWELL-1.
// Latency: tc is combinational from the registered count; clr/rst take effect next edge.
// Backpressure: none.
module scan_dwell_cnt #(
   parameter int CW    = decoder_scan_pkg::DWELL_W,
   parameter int DWELL = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);
   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clr)
         count <= '0;
      else if (en)
         count <= count + 1'b1;
   end

   assign tc = (count == CW'(DWELL - 1));

endmodule

// File: rtl/decoder_scan_seq.sv
// Sweeps decoder select B/enable E over [first..last], auto dwell or single-step; DECODER_SCAN_LOOP_EN adds looping.
// Latency: start to first E=1 is 1 cycle; each auto index held DWELL cycles; done 1 cycle after last index.
// Backpressure: none; start while busy is ignored, stop aborts immediately.
module decoder_scan_seq
   import decoder_scan_pkg::*;
#(
   parameter int IDX_W = IDX_W_DEF,
   parameter int DWELL = 4
) (
   input  logic               clk,
   input  logic               rst,
   decoder_scan_seq_if.slave  bus
);
   state_t           state, state_nxt;
   logic [IDX_W-1:0] b_q, b_nxt;
   logic [IDX_W-1:0] last_q, last_nxt;
   logic             e_q, e_nxt;
   logic             busy_q, busy_nxt;
   logic             done_q, done_nxt;
   logic             up_q, up_nxt;
   logic             mode_q, mode_nxt;
   logic             cnt_clr, cnt_en, tc;
   logic             advance, at_last;
   logic             loop_hit;
   logic [IDX_W-1:0] reload_b;

   scan_dwell_cnt #(
      .CW    (DWELL_W),
      .DWELL (DWELL)
   ) u_dwell (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .en  (cnt_en),
      .tc  (tc)
   );

`ifdef DECODER_SCAN_LOOP_EN
   logic [IDX_W-1:0] first_q;
   logic             loop_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         first_q <= '0;
         loop_q  <= 1'b0;
      end else if (state == S_IDLE && bus.start && !bus.stop) begin
         first_q <= bus.first;
         loop_q  <= bus.loop;
      end
   end

   assign loop_hit = loop_q;
   assign reload_b = first_q;
`else
   assign loop_hit = 1'b0;
   assign reload_b = b_q;
`endif

   assign advance = mode_q ? bus.step : tc;
   assign at_last = (b_q == last_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         b_q    <= '0;
         last_q <= '0;
         e_q    <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         up_q   <= 1'b1;
         mode_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         b_q    <= b_nxt;
         last_q <= last_nxt;
         e_q    <= e_nxt;
         busy_q <= busy_nxt;
         done_q <= done_nxt;
         up_q   <= up_nxt;
         mode_q <= mode_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      b_nxt     = b_q;
      last_nxt  = last_q;
      e_nxt     = e_q;
      busy_nxt  = busy_q;
      done_nxt  = 1'b0;
      up_nxt    = up_q;
      mode_nxt  = mode_q;
      cnt_clr   = 1'b0;
      cnt_en    = 1'b0;

      case (state)
         S_IDLE: begin
            e_nxt    = 1'b0;
            busy_nxt = 1'b0;
            if (bus.start && !bus.stop) begin
               state_nxt = S_RUN;
               b_nxt     = bus.first;
               last_nxt  = bus.last;
               up_nxt    = (bus.last >= bus.first);
               mode_nxt  = bus.step_mode;
               e_nxt     = 1'b1;
               busy_nxt  = 1'b1;
               cnt_clr   = 1'b1;
            end
         end
         S_RUN: begin
            if (bus.stop) begin
               state_nxt = S_IDLE;
               e_nxt     = 1'b0;
               busy_nxt  = 1'b0;
               cnt_clr   = 1'b1;
            end else if (advance) begin
               cnt_clr = 1'b1;
               if (!at_last) begin
                  b_nxt = up_q ? b_q + 1'b1 : b_q - 1'b1;
               end else if (loop_hit) begin
                  // Looping pass boundary: reload without dropping E, still flag the pass.
                  b_nxt    = reload_b;
                  done_nxt = 1'b1;
               end else begin
                  state_nxt = S_FIN;
                  e_nxt     = 1'b0;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
               end
            end else begin
               cnt_en = !mode_q;
            end
         end
         S_FIN: begin
            state_nxt = S_IDLE;
            e_nxt     = 1'b0;
            busy_nxt  = 1'b0;
         end
         default: begin
            state_nxt = S_IDLE;
            e_nxt     = 1'b0;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   assign bus.B    = b_q;
   assign bus.E    = e_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Bench for decoder_scan_seq with DWELL=2: vector table plus a modelled full 0..31 sweep.
module tb_decoder_scan_seq;
   localparam int IW = 5;
   localparam int DW = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   decoder_scan_seq_if #(.IDX_W(IW)) bus ();

   decoder_scan_seq #(.IDX_W(IW), .DWELL(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic          rst;
      logic          start;
      logic          stop;
      logic          mode;
      logic          step;
      logic          lp;
      logic [IW-1:0] first;
      logic [IW-1:0] last;
      logic [IW+2:0] exp;   // {B, E, busy, done}
   } vec_t;

   vec_t          vecs[$];
   logic [IW+2:0] exp_q[$];
   int            checks = 0;
   int            errors = 0;

   function automatic vec_t mk(input logic r, input logic s, input logic p, input logic m,
                               input logic st, input logic l, input int f, input int la,
                               input int b, input logic e, input logic bz, input logic d);
      vec_t v;
      v.rst = r; v.start = s; v.stop = p; v.mode = m; v.step = st; v.lp = l;
      v.first = IW'(f); v.last = IW'(la);
      v.exp = {IW'(b), e, bz, d};
      return v;
   endfunction

   function automatic vec_t nop(input int b, input logic e, input logic bz, input logic d);
      return mk(0, 0, 0, 0, 0, 0, 0, 0, b, e, bz, d);
   endfunction

   task automatic apply(input vec_t t, input string tag, input int idx);
      logic [IW+2:0] want, got;
      @(negedge clk);
      rst           = t.rst;
      bus.start     = t.start;
      bus.stop      = t.stop;
      bus.step_mode = t.mode;
      bus.step      = t.step;
      bus.first     = t.first;
      bus.last      = t.last;
`ifdef DECODER_SCAN_LOOP_EN
      bus.loop      = t.lp;
`endif
      exp_q.push_back(t.exp);
      @(posedge clk);
      #1;
      want = exp_q.pop_front();
      got  = {bus.B, bus.E, bus.busy, bus.done};
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s %0d: got B=%0d E=%b busy=%b done=%b, expected B=%0d E=%b busy=%b done=%b",
                  tag, idx, got[IW+2:3], got[2], got[1], got[0],
                  want[IW+2:3], want[2], want[1], want[0]);
      end
   endtask

   initial begin
      bus.start = 0; bus.stop = 0; bus.step_mode = 0; bus.step = 0;
      bus.first = '0; bus.last = '0;
`ifdef DECODER_SCAN_LOOP_EN
      bus.loop = 0;
`endif

      // reset held 3 cycles with a start that must be ignored
      for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 1, 0, 0, 0, 0, 5, 6, 0, 0, 0, 0));
      vecs.push_back(nop(0, 0, 0, 0));

      // auto up-sweep 1..4; a start mid-sweep is ignored
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 4, 1, 1, 1, 0));
      vecs.push_back(nop(1, 1, 1, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 20, 25, 2, 1, 1, 0));
      vecs.push_back(nop(2, 1, 1, 0));
      vecs.push_back(nop(3, 1, 1, 0));
      vecs.push_back(nop(3, 1, 1, 0));
      vecs.push_back(nop(4, 1, 1, 0));
      vecs.push_back(nop(4, 1, 1, 0));
      vecs.push_back(nop(4, 0, 0, 1));
      vecs.push_back(nop(4, 0, 0, 0));

      // auto down-sweep 8..6
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 8, 6, 8, 1, 1, 0));
      vecs.push_back(nop(8, 1, 1, 0));
      vecs.push_back(nop(7, 1, 1, 0));
      vecs.push_back(nop(7, 1, 1, 0));
      vecs.push_back(nop(6, 1, 1, 0));
      vecs.push_back(nop(6, 1, 1, 0));
      vecs.push_back(nop(6, 0, 0, 1));
      vecs.push_back(nop(6, 0, 0, 0));

      // single index at the top of the range, no wrap
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 31, 31, 31, 1, 1, 0));
      vecs.push_back(nop(31, 1, 1, 0));
      vecs.push_back(nop(31, 0, 0, 1));
      vecs.push_back(nop(31, 0, 0, 0));

      // step mode 0..2, step gaps 1, 3, 0
      vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 2, 0, 1, 1, 0));
      vecs.push_back(nop(0, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0));
      for (int i = 0; i < 3; i++) vecs.push_back(nop(1, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 2, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 2, 0, 0, 1));
      vecs.push_back(nop(2, 0, 0, 0));

      // stop on 3rd RUN cycle of 0..7, with a concurrent start; then start+stop in idle
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 7, 0, 1, 1, 0));
      vecs.push_back(nop(0, 1, 1, 0));
      vecs.push_back(nop(1, 1, 1, 0));
      vecs.push_back(mk(0, 1, 1, 0, 0, 0, 5, 9, 1, 0, 0, 0));
      vecs.push_back(nop(1, 0, 0, 0));
      vecs.push_back(nop(1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 0, 0, 0, 5, 9, 1, 0, 0, 0));
      vecs.push_back(nop(1, 0, 0, 0));

      // reset mid-sweep aborts without done
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 3, 5, 3, 1, 1, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(nop(0, 0, 0, 0));

      foreach (vecs[i]) apply(vecs[i], "vec", i);

      // full-range sweep 0..31: B must equal k/DWELL on the k-th E=1 cycle
      apply(mk(0, 1, 0, 0, 0, 0, 0, 31, 0, 1, 1, 0), "sweep", 0);
      for (int k = 1; k < 32 * DW; k++) apply(nop(k / DW, 1, 1, 0), "sweep", k);
      apply(nop(31, 0, 0, 1), "sweep_done", 0);
      apply(nop(31, 0, 0, 0), "sweep_idle", 0);

`ifdef DECODER_SCAN_LOOP_EN
      // looping 2..3: done per pass, E held until stop
      apply(mk(0, 1, 0, 0, 0, 1, 2, 3, 2, 1, 1, 0), "loop", 0);
      for (int p = 0; p < 2; p++) begin
         apply(nop(2, 1, 1, 0), "loop", 1);
         apply(nop(3, 1, 1, 0), "loop", 2);
         apply(nop(3, 1, 1, 0), "loop", 3);
         apply(nop(2, 1, 1, 1), "loop", 4);
      end
      apply(mk(0, 0, 1, 0, 0, 0, 0, 0, 2, 0, 0, 0), "loop_stop", 0);
      apply(nop(2, 0, 0, 0), "loop_idle", 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
